// File: rtl/musico_pkg.sv
// Shared definitions for the song player and the note-to-Y video decoder.
package musico_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] NOTE_DO    = 8'h80;
    localparam logic [7:0] NOTE_RE    = 8'h40;
    localparam logic [7:0] NOTE_MI    = 8'h20;
    localparam logic [7:0] NOTE_FA    = 8'h10;
    localparam logic [7:0] NOTE_SOL   = 8'h08;
    localparam logic [7:0] NOTE_LA    = 8'h04;
    localparam logic [7:0] NOTE_SI    = 8'h02;
    localparam logic [7:0] NOTE_DO_HI = 8'h01;

    localparam logic [7:0] END_MARKER = 8'h00;

    // Exactly one bit set; zero is not one-hot.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

endpackage

// File: rtl/note_duration_counter.sv
// Beat down-counter for the current note; a zero duration plays as one beat.
module note_duration_counter #(
    parameter int DUR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] value,
    input  logic             pending,
    input  logic             run,
    input  logic             tick,
    output logic             expire
);

    logic [DUR_W-1:0] cnt;
    logic [DUR_W-1:0] base;

    assign base = (value == '0) ? DUR_W'(1) : value;

    // A tick seen between notes is charged against the new note at load time.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= base - DUR_W'(pending);
        end else if (run && tick && (cnt != '0)) begin
            cnt <= cnt - DUR_W'(1);
        end
    end

    // A count already at zero in PLAY means the pending tick used up the note.
    assign expire = run && ((cnt == '0) || ((cnt == DUR_W'(1)) && tick));

endmodule

// File: rtl/song_note_sequencer.sv
// Walks the song ROM entry by entry, timing each note in beats and driving
// the current note plus its qualifier to the video path.
module song_note_sequencer
    import musico_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                beat_tick,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [8+DUR_W-1:0]  rom_data,
    output logic [7:0]          nota_cancion,
    output logic                leyendo,
    output logic                note_strobe,
    output logic                song_done,
    output logic                busy
);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             pend;
    logic             expire;
    logic             is_end;
    logic             last_addr;
    logic [7:0]       entry_note;
    logic [DUR_W-1:0] entry_dur;

    assign entry_note = rom_data[8+DUR_W-1:DUR_W];
    assign entry_dur  = rom_data[DUR_W-1:0];
    assign is_end     = (entry_note == END_MARKER) && (entry_dur == '0);
    assign last_addr  = &rom_addr;
    assign busy       = (state != ST_IDLE);

    note_duration_counter #(
        .DUR_W (DUR_W)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .clear   (stop),
        .load    ((state == ST_LOAD) && !is_end),
        .value   (entry_dur),
        .pending (pend || beat_tick),
        .run     (state == ST_PLAY),
        .tick    (beat_tick),
        .expire  (expire)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_LOAD;
            ST_LOAD:  state_nx = is_end ? ST_DONE : ST_PLAY;
            ST_PLAY:  if (expire) state_nx = last_addr ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (stop) state_nx = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            rom_addr     <= '0;
            pend         <= 1'b0;
            nota_cancion <= 8'h00;
            leyendo      <= 1'b0;
            note_strobe  <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            state       <= state_nx;
            note_strobe <= 1'b0;
            song_done   <= 1'b0;
            if (stop) begin
                rom_addr     <= '0;
                pend         <= 1'b0;
                nota_cancion <= 8'h00;
                leyendo      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) rom_addr <= '0;
                    // Display holds the previous note while the next one is fetched.
                    ST_FETCH: if (beat_tick) pend <= 1'b1;
                    ST_LOAD: begin
                        pend <= 1'b0;
                        if (!is_end) begin
                            nota_cancion <= is_onehot(entry_note) ? entry_note : 8'h00;
                            leyendo      <= 1'b1;
                            note_strobe  <= 1'b1;
                        end
                    end
                    ST_PLAY: if (expire && !last_addr) rom_addr <= rom_addr + ADDR_W'(1);
                    default: ;
                endcase
                if (state_nx == ST_DONE) begin
                    song_done    <= 1'b1;
                    nota_cancion <= 8'h00;
                    leyendo      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/song_note_sequencer.md
# song_note_sequencer

Plays a song stored in a synchronous song ROM by sequencing its entries one at a time. Each entry holds a one-hot note and a duration in beats. The block drives the current note code, plus the `leyendo` qualifier, into the note-to-Y-position video decoder. It sits between the song ROM, the global beat-tick generator and the note video path, and reports start/end-of-song status to the top-level game FSM.

## Interface
Parameters:
- `ADDR_W`, default 8: song ROM address width; the maximum song length is 2^ADDR_W entries.
- `DUR_W`, default 8: width of the duration field in beats.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse; begins playback at address 0. Ignored unless in IDLE.
- `stop`, in, 1: abort playback. Wins over `start` when both are asserted.
- `beat_tick`, in, 1: one-cycle strobe, one per beat.
- `rom_addr`, out, ADDR_W: song ROM address.
- `rom_data`, in, 8+DUR_W: entry contents; `[8+DUR_W-1:DUR_W]` is the note, `[DUR_W-1:0]` is the duration. The ROM is registered, so data is valid 1 cycle after the address.
- `nota_cancion`, out, 8: current one-hot note. 0x80 = DO … 0x01 = high DO; 0 = rest/none.
- `leyendo`, out, 1: playback active; qualifies `nota_cancion` for the video decoder.
- `note_strobe`, out, 1: one-cycle pulse when a new entry takes effect.
- `song_done`, out, 1: one-cycle pulse when the song ends naturally (not on `stop`).
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, FETCH, LOAD, PLAY, DONE.
- **IDLE**: `start` (without `stop`) sets `rom_addr` to 0 and moves to FETCH.
- **FETCH**: the address is presented to the ROM; move to LOAD unconditionally.
- **LOAD**: latch `rom_data`, then classify the entry:
  - Note = 0 and duration = 0 is the end marker: go to DONE.
  - Otherwise set `nota_cancion` to the note code. A nonzero code that is not one-hot is output as 0 (rest).
  - Load the beat counter with the duration; a duration of 0 is treated as 1.
  - Pulse `note_strobe`, set `leyendo` to 1, and go to PLAY.
- **PLAY**: each `beat_tick` decrements the counter. A tick that arrives while the counter is 1:
  - If `rom_addr` is the last address (2^ADDR_W−1), go to DONE. Addresses never wrap.
  - Otherwise increment `rom_addr` and go to FETCH.
- **Between notes** (FETCH, LOAD): `nota_cancion` and `leyendo` hold their previous values, so the display does not flicker.
  - A `beat_tick` arriving in FETCH or LOAD sets a pending flag, which saturates at 1.
  - In LOAD the pending tick is applied to the newly loaded counter. A loaded duration of 1 plus a pending tick finishes the note after 0 further ticks; the next fetch is then taken from PLAY on its first cycle.
- **DONE**: pulse `song_done` for 1 cycle, clear `nota_cancion` and `leyendo`, return to IDLE.
- **`stop`** in any state: next cycle the FSM is in IDLE; `nota_cancion`, `leyendo`, `busy`, `rom_addr` and the pending flag are all 0; no `song_done`.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- `start` at cycle T gives the following sequence:
  - T+1: FETCH, `rom_addr` = 0.
  - T+2: LOAD.
  - T+3: `nota_cancion` valid, `note_strobe` = 1, `leyendo` = 1.
- Note-to-note latency: the last tick at cycle T gives the new note visible at T+3, and `note_strobe` at T+3.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `reset` mid-song is equivalent to `stop`; it also clears the counter and the pending flag.

## Structure
- Shared package `musico_pkg` holds:
  - State enumeration.
  - Note constants NOTE_DO=8'h80, NOTE_RE=8'h40, NOTE_MI=8'h20, NOTE_FA=8'h10, NOTE_SOL=8'h08, NOTE_LA=8'h04, NOTE_SI=8'h02, NOTE_DO_HI=8'h01.
  - END_MARKER=0.
  - `is_onehot` function, shared with the video decoder.
- One sub-module, `note_duration_counter`:
  - Inputs: load, value, tick, pending.
  - Behaviour: DUR_W down-counter with zero-as-one handling.
  - Output: `expire` pulse.
- The FSM and address register live in the top level.

## Test plan
- Song {0x80/2, 0x20/1, END}, ticks every 10 cycles:
  - `start` → `nota_cancion` 0x80 at start+3, then 0x20 after 2 ticks, then `song_done` after 1 more tick.
  - `note_strobe` pulses exactly 2 times; `leyendo` falls in the same cycle `song_done` pulses.
- Entry {0x06, 3}: output is 0 (rest), `leyendo`=1, lasts 3 ticks.
- Entry {0x04, 0}: treated as 1 beat.
- `beat_tick` during LOAD with the next entry {0x08, 1}: the note expires without further ticks; next fetch is issued immediately.
- `stop` and `start` asserted together mid-song: next cycle IDLE with all outputs 0 and no `song_done`. A later `start` replays from address 0.
- ADDR_W=2, ROM full of {0x01, 1} with no end marker: 4 notes play, `song_done` pulses after the 4th tick, `rom_addr` never returns to 0 while busy.
- `reset` asserted during PLAY: next cycle all outputs 0 and state IDLE.
